// File: rtl/imem_fetch_responder.sv
// rtl/imem_fetch_responder.sv - instruction-memory fetch responder with programmable latency
module imem_fetch_responder #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DEPTH_LOG2 = 10,
    parameter int                    LATENCY    = 2,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h8000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_err,
    input  logic                  wr_en,
    input  logic [DEPTH_LOG2-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data
);

    localparam int         DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [3:0] LAT_LOAD = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t                  state;
    state_t                  state_d;
    logic [3:0]              cnt;
    logic [3:0]              cnt_d;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [ADDR_WIDTH-1:0]   rd_addr;
    logic [ADDR_WIDTH-3:0]   word_off;
    logic [DEPTH_LOG2-1:0]   rd_idx;
    logic                    rd_err;
    logic                    rd_fire;
    logic [DATA_WIDTH-1:0]   data_q;
    logic                    err_q;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    // With zero latency the read happens on the accept edge, so the live address is used.
    assign rd_addr = (state == S_IDLE) ? req_addr : addr_q;

    // BASE_ADDR is word aligned, so the offset can be formed on word addresses directly.
    assign word_off = rd_addr[ADDR_WIDTH-1:2] - BASE_ADDR[ADDR_WIDTH-1:2];
    assign rd_idx   = word_off[DEPTH_LOG2-1:0];
    assign rd_err   = (rd_addr[1:0] != 2'b00) || (word_off[ADDR_WIDTH-3:DEPTH_LOG2] != '0);

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        rd_fire = 1'b0;
        case (state)
            S_IDLE: begin
                if (req_valid) begin
                    if (LATENCY == 0) begin
                        state_d = S_RESP;
                        rd_fire = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = LAT_LOAD;
                    end
                end
            end
            S_WAIT: begin
                if (cnt == 4'd0) begin
                    state_d = S_RESP;
                    rd_fire = 1'b1;
                end else begin
                    cnt_d = cnt - 4'd1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= S_IDLE;
            cnt    <= 4'd0;
            addr_q <= '0;
            data_q <= '0;
            err_q  <= 1'b0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            if (state == S_IDLE && req_valid) begin
                addr_q <= req_addr;
            end
            if (rd_fire) begin
                err_q  <= rd_err;
                data_q <= rd_err ? '0 : mem[rd_idx];
            end else if (state == S_RESP && rsp_ready) begin
                err_q  <= 1'b0;
                data_q <= '0;
            end
        end
    end

    // Array is not reset; a same-edge write lands after the response register sampled the old word.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign req_ready = (state == S_IDLE);
    assign rsp_valid = (state == S_RESP);
    assign rsp_data  = data_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_imem_fetch_responder.sv
// tb/tb_imem_fetch_responder.sv - self-checking bench for imem_fetch_responder
module tb_imem_fetch_responder;

    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int          LAT_A = 2;
    localparam int          WORDS = 1024;

    logic        clk;
    logic        rst;
    logic        rsp_ready;
    logic        wr_en;
    logic [9:0]  wr_addr;
    logic [31:0] wr_data;

    logic        req_valid_a, req_ready_a, rsp_valid_a, rsp_err_a;
    logic [31:0] req_addr_a, rsp_data_a;
    logic        req_valid_b, req_ready_b, rsp_valid_b, rsp_err_b;
    logic [31:0] req_addr_b, rsp_data_b;

    logic [31:0] ref_mem [WORDS];
    int          checks = 0;
    int          errors = 0;

    imem_fetch_responder #(.LATENCY(LAT_A)) u_dut_a (
        .clk(clk), .rst(rst),
        .req_valid(req_valid_a), .req_ready(req_ready_a), .req_addr(req_addr_a),
        .rsp_valid(rsp_valid_a), .rsp_ready(rsp_ready), .rsp_data(rsp_data_a), .rsp_err(rsp_err_a),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    imem_fetch_responder #(.LATENCY(0)) u_dut_b (
        .clk(clk), .rst(rst),
        .req_valid(req_valid_b), .req_ready(req_ready_b), .req_addr(req_addr_b),
        .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready), .rsp_data(rsp_data_b), .rsp_err(rsp_err_b),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_word(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [9:0] widx(input logic [31:0] a);
        logic [31:0] t;
        t = (a - BASE) >> 2;
        return t[9:0];
    endfunction

    // Reference: byte offset from base as a true signed distance, bounds-checked against the array size.
    function automatic void ref_fetch(input logic [31:0] a, output logic e, output logic [31:0] d);
        longint off;
        off = longint'({32'd0, a}) - longint'({32'd0, BASE});
        e = 1'b1;
        d = 32'd0;
        if ((a % 32'd4) == 32'd0 && off >= 0 && off < 4 * WORDS) begin
            e = 1'b0;
            d = ref_mem[int'(off / 4)];
        end
    endfunction

    function automatic logic [31:0] gen_addr();
        int k;
        k = $urandom_range(0, 9);
        case (k)
            0:       return BASE + 32'(4 * $urandom_range(0, WORDS - 1)) + 32'($urandom_range(1, 3));
            1:       return BASE + 32'(4 * WORDS) + 32'(4 * $urandom_range(0, 255));
            2:       return BASE - 32'(4 * $urandom_range(1, 255));
            default: return BASE + 32'(4 * $urandom_range(0, WORDS - 1));
        endcase
    endfunction

    task automatic preload(input logic [9:0] idx, input logic [31:0] dat);
        wr_en   = 1'b1;
        wr_addr = idx;
        wr_data = dat;
        ref_mem[idx] = dat;
        step();
        wr_en = 1'b0;
    endtask

    // One fetch on the LATENCY=2 instance. Sample point s follows edge s after the accept edge;
    // wr_edge (1..3, 0 = none) places a preload write to the fetched word on that edge.
    task automatic fetch_a(input logic [31:0] addr, input int stall, input int wr_edge,
                           input logic [31:0] wdat);
        logic [31:0] exp_d;
        logic        exp_e;
        int          last;
        exp_d = 32'd0;
        exp_e = 1'b0;
        last  = LAT_A + stall + 1;
        chk_bit("a_ready_idle", req_ready_a, 1'b1);
        req_valid_a = 1'b1;
        req_addr_a  = addr;
        rsp_ready   = 1'b0;
        step();
        for (int s = 0; s <= last; s++) begin
            if (s < LAT_A) begin
                chk_bit("a_wait_valid", rsp_valid_a, 1'b0);
                chk_bit("a_wait_ready", req_ready_a, 1'b0);
            end
            if (s == LAT_A - 1) ref_fetch(addr, exp_e, exp_d);
            if (s >= LAT_A && s < last) begin
                chk_bit("a_rsp_valid", rsp_valid_a, 1'b1);
                chk_word("a_rsp_data", rsp_data_a, exp_d);
                chk_bit("a_rsp_err", rsp_err_a, exp_e);
                chk_bit("a_rsp_ready_low", req_ready_a, 1'b0);
            end
            if (s == last) begin
                chk_bit("a_done_valid", rsp_valid_a, 1'b0);
                chk_word("a_done_data", rsp_data_a, 32'd0);
                chk_bit("a_done_err", rsp_err_a, 1'b0);
                chk_bit("a_done_ready", req_ready_a, 1'b1);
            end
            req_valid_a = (s < last) ? 1'($urandom_range(0, 1)) : 1'b0;
            req_addr_a  = $urandom;
            rsp_ready   = (s >= LAT_A + stall);
            if (s + 1 == wr_edge) begin
                wr_en   = 1'b1;
                wr_addr = widx(addr);
                wr_data = wdat;
                ref_mem[widx(addr)] = wdat;
            end else begin
                wr_en = 1'b0;
            end
            if (s < last) step();
        end
    endtask

    // Back-to-back fetches on the LATENCY=0 instance with req_valid held high.
    task automatic burst_b(input int n);
        logic [31:0] addr, d;
        logic        e;
        rsp_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            addr = (i == 2) ? BASE + 32'(4 * $urandom_range(0, WORDS - 1)) : gen_addr();
            chk_bit("b_ready_idle", req_ready_b, 1'b1);
            req_valid_b = 1'b1;
            req_addr_b  = addr;
            ref_fetch(addr, e, d);
            if (i == 2) begin
                wr_en   = 1'b1;
                wr_addr = widx(addr);
                wr_data = $urandom;
                ref_mem[widx(addr)] = wr_data;
            end
            step();
            wr_en = 1'b0;
            chk_bit("b_rsp_valid", rsp_valid_b, 1'b1);
            chk_word("b_rsp_data", rsp_data_b, d);
            chk_bit("b_rsp_err", rsp_err_b, e);
            chk_bit("b_rsp_ready_low", req_ready_b, 1'b0);
            req_addr_b = $urandom;
            step();
            chk_bit("b_done_valid", rsp_valid_b, 1'b0);
            chk_bit("b_done_ready", req_ready_b, 1'b1);
        end
        req_valid_b = 1'b0;
    endtask

    // Asynchronous reset asserted at sample point at_s after accept, then released mid-cycle.
    task automatic reset_mid(input logic [31:0] addr, input int at_s);
        chk_bit("r_ready_idle", req_ready_a, 1'b1);
        req_valid_a = 1'b1;
        req_addr_a  = addr;
        rsp_ready   = 1'b0;
        step();
        req_valid_a = 1'b0;
        for (int s = 0; s < at_s; s++) step();
        if (at_s >= LAT_A) chk_bit("r_pre_valid", rsp_valid_a, 1'b1);
        #2 rst = 1'b0;
        #1;
        chk_bit("r_async_valid", rsp_valid_a, 1'b0);
        chk_word("r_async_data", rsp_data_a, 32'd0);
        chk_bit("r_async_err", rsp_err_a, 1'b0);
        chk_bit("r_async_ready", req_ready_a, 1'b1);
        step();
        step();
        rst       = 1'b1;
        rsp_ready = 1'b1;
        for (int s = 0; s < LAT_A + 3; s++) begin
            step();
            chk_bit("r_no_stale", rsp_valid_a, 1'b0);
            chk_bit("r_idle_ready", req_ready_a, 1'b1);
        end
    endtask

    initial begin
        rst         = 1'b0;
        rsp_ready   = 1'b0;
        wr_en       = 1'b0;
        wr_addr     = '0;
        wr_data     = '0;
        req_valid_a = 1'b0;
        req_addr_a  = '0;
        req_valid_b = 1'b0;
        req_addr_b  = '0;

        step();
        chk_bit("reset_valid_a", rsp_valid_a, 1'b0);
        chk_word("reset_data_a", rsp_data_a, 32'd0);
        chk_bit("reset_err_a", rsp_err_a, 1'b0);
        chk_bit("reset_ready_a", req_ready_a, 1'b1);
        chk_bit("reset_valid_b", rsp_valid_b, 1'b0);
        chk_bit("reset_ready_b", req_ready_b, 1'b1);
        step();
        rst = 1'b1;

        for (int i = 0; i < WORDS; i++) preload(10'(i), $urandom);
        preload(10'd0, 32'h0000_0413);
        preload(10'd1, 32'h0010_0093);

        fetch_a(BASE, 0, 0, 32'd0);
        fetch_a(BASE + 32'd4, 0, 0, 32'd0);
        fetch_a(BASE + 32'd28, 5, 0, 32'd0);

        fetch_a(32'h8000_0002, 0, 0, 32'd0);
        fetch_a(32'h8000_1000, 1, 0, 32'd0);
        fetch_a(32'h7FFF_FFFC, 0, 0, 32'd0);
        fetch_a(32'h8000_0FFC, 0, 0, 32'd0);

        fetch_a(BASE + 32'd8, 0, 1, 32'hDEAD_0001);
        fetch_a(BASE + 32'd12, 0, 2, 32'hDEAD_0002);
        fetch_a(BASE + 32'd16, 2, 3, 32'hDEAD_0003);
        fetch_a(BASE + 32'd12, 0, 0, 32'd0);
        fetch_a(BASE + 32'd16, 0, 0, 32'd0);

        burst_b(12);

        reset_mid(BASE + 32'd4, 0);
        reset_mid(BASE + 32'd4, LAT_A);
        fetch_a(BASE + 32'd4, 0, 0, 32'd0);

        rst = 1'b0;
        step();
        rst = 1'b1;
        fetch_a(BASE, 1, 0, 32'd0);

        for (int i = 0; i < 40; i++) begin
            fetch_a(gen_addr(), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), $urandom);
        end
        burst_b(12);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
